// File: rtl/linecard_uplink_arbiter.sv
// Frame-granular round-robin merge of the line-card RX streams onto one uplink.
// Runt and runaway frames are closed with an error beat, so egress never stalls mid-frame.
module linecard_uplink_arbiter #(
  parameter int NUM_PORTS       = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_FRAME_BEATS = 512,
  parameter int PORT_BITS       = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            link_up,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  input  logic [NUM_PORTS-1:0]            s_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [DATA_WIDTH/8-1:0]         m_tkeep,
  output logic                            m_tlast,
  output logic                            m_tuser,
  output logic [PORT_BITS-1:0]            m_tdest,
  output logic [31:0]                     frame_count,
  output logic [15:0]                     error_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = $clog2(MAX_FRAME_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DRAIN,
    ABORT
  } state_t;

  state_t               state;
  logic [PORT_BITS-1:0] grant;
  logic [PORT_BITS-1:0] last_grant;
  logic [PORT_BITS-1:0] pick;
  logic [PORT_BITS-1:0] cand;
  logic [BW-1:0]        beats;
  logic [NUM_PORTS-1:0] elig;
  logic                 found;
  logic                 free;
  logic                 take;
  logic                 oversize;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KW-1:0]        g_keep;
  logic                 g_valid;
  logic                 g_last;
  logic                 g_user;
  logic                 g_link;

  assign free     = !m_tvalid || m_tready;
  assign elig     = link_up & s_tvalid;
  assign take     = (state == FORWARD) && g_valid && free;
  assign oversize = (beats == BW'(MAX_FRAME_BEATS - 1));

  always_comb begin
    g_data  = s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    g_keep  = s_tkeep[grant*KW +: KW];
    g_valid = s_tvalid[grant];
    g_last  = s_tlast[grant];
    g_user  = s_tuser[grant];
    g_link  = link_up[grant];
  end

  // Rotating search starting one past the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (cand == PORT_BITS'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    s_tready = '0;
    unique case (1'b1)
      state == FORWARD: s_tready[grant] = free;
      state == DRAIN:   s_tready[grant] = 1'b1;
      default:          s_tready = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= PORT_BITS'(NUM_PORTS - 1);
      beats       <= '0;
      m_tvalid    <= 1'b0;
      m_tdata     <= '0;
      m_tkeep     <= '0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      m_tdest     <= '0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (free)
        m_tvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            beats <= '0;
            state <= FORWARD;
          end
        end
        FORWARD: begin
          if (take) begin
            m_tvalid <= 1'b1;
            m_tdata  <= g_data;
            m_tkeep  <= g_keep;
            m_tdest  <= grant;
            beats    <= beats + 1'b1;
            if (g_last) begin
              m_tlast     <= 1'b1;
              m_tuser     <= g_user;
              last_grant  <= grant;
              frame_count <= frame_count + 32'd1;
              state       <= IDLE;
            end else if (oversize) begin
              m_tlast     <= 1'b1;
              m_tuser     <= 1'b1;
              frame_count <= frame_count + 32'd1;
              if (error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
              state       <= DRAIN;
            end else begin
              m_tlast <= 1'b0;
              m_tuser <= g_user;
              if (!g_link)
                state <= ABORT;
            end
          end else if (!g_link) begin
            state <= ABORT;
          end
        end
        DRAIN: begin
          if ((g_valid && g_last) || !g_link) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        ABORT: begin
          // Close the half-frame with an empty error beat.
          if (free) begin
            m_tvalid    <= 1'b1;
            m_tdata     <= '0;
            m_tkeep     <= '0;
            m_tlast     <= 1'b1;
            m_tuser     <= 1'b1;
            m_tdest     <= grant;
            frame_count <= frame_count + 32'd1;
            if (error_count != 16'hFFFF)
              error_count <= error_count + 16'd1;
            last_grant  <= grant;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
